mips_multicycle_core: RTL and testbench
=======================================

# mips_multicycle_core

Parametrised multi-cycle core for the MIPS-subset used across the course designs. It executes one instruction every six cycles from an external instruction ROM port and holds a register file and a data memory internally. Over the previous fixed 8-bit core it adds:
- configurable data width and memory depths;
- synchronous reset, a start handshake and a data-memory preload port;
- the `sw` store instruction;
- sign-extended immediates and a sticky invalid-instruction flag.

It sits under the assignment testbenches as the device under test.

## Interface
- `DATA_W`, 8: register and data-memory word width, at least 2.
- `IMEM_AW`, 4: instruction address width. ROM depth is 2^IMEM_AW.
- `DMEM_DEPTH`, 8: number of data-memory words.
- `PROG_LEN`, 11: execution halts once pc ≥ PROG_LEN after an instruction completes.
- `OUTPUT_REG`, 4: register copied to `final_result` at halt.
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin execution. Sampled only in IDLE or DONE.
- `dm_we` input 1: preload write strobe. Honoured only in IDLE.
- `dm_waddr` input $clog2(DMEM_DEPTH): preload address.
- `dm_wdata` input DATA_W: preload data.
- `imem_addr` output IMEM_AW: current pc.
- `imem_rdata` input 32: instruction word, combinational from `imem_addr`.
- `done` output 1: program finished. Held high until restart or reset.
- `final_result` output DATA_W, signed: value of `Registerfile[OUTPUT_REG]`, captured at halt.
- `invalid_seen` output 1: sticky. Set by any invalid opcode or funct, or an out-of-range data address.

## Operation
States and transitions:
- IDLE → FETCH on `start`.
- FETCH → DECODE → READ → EXEC → MEM → WB.
- WB → FETCH if pc < PROG_LEN, otherwise → DONE.
- DONE → FETCH on `start`.

Per-state actions:
- FETCH latches `imem_rdata` into the instruction register.
- DECODE extracts rs, rt, rd, funct, imm16 and target.
- READ reads rs and rt. Register 0 always reads 0.
- EXEC computes the ALU result and next pc.
- MEM performs the lw read or the sw write.
- WB writes the register file and commits pc.

Instructions:
- `addu` (op 0, funct 33): rd = rs + rt, modulo 2^DATA_W.
- `slt` (funct 42): rd = 1 if signed rs < rt, else 0.
- `jr` (funct 8): halt. Go to DONE after WB with no register write.
- `addiu` (op 9): rt = rs + sext(imm16), truncated to DATA_W.
- `beq` (op 4) and `bne` (op 5): if taken, pc = pc + sext(imm16), relative to the branch itself. Otherwise pc + 1. Result wraps modulo 2^IMEM_AW.
- `j` (op 2): pc = target[IMEM_AW-1:0].
- `lw` (op 35): rt = dmem[rs + sext(imm16)].
- `sw` (op 43): dmem[rs + sext(imm16)] = rt.

Rules:
- Writes to register 0 are discarded.
- An invalid opcode or funct sets `invalid_seen`, performs no write and advances pc + 1.
- An lw or sw effective address ≥ DMEM_DEPTH, taken as unsigned, sets `invalid_seen`. The access is suppressed: lw does not write rt, sw does not write memory. pc advances + 1.
- A `start` in DONE clears `done` and sets pc to 0. Registers, dmem and `invalid_seen` are retained.

## Timing
- Reset values: state IDLE, pc 0, all registers 0, `done` 0, `final_result` 0, `invalid_seen` 0. Dmem is cleared to 0.
- Reset mid-instruction aborts the instruction. No partial write survives.
- If `start` is sampled at edge N, FETCH occupies cycle N+1. Each instruction takes exactly 6 cycles.
- After k instructions, `done` and `final_result` are valid from cycle N+1+6k, and hold until the next start or reset.
- A `dm_we` at the same edge as `start` in IDLE is still written.
- `start` and `dm_we` outside their allowed states are ignored.

## Configuration
- `MIPS_SW_STORE_EN` defined: op 43 executes as `sw` as described above.
- `MIPS_SW_STORE_EN` undefined:
  - op 43 is treated as an invalid opcode;
  - dmem is writable only through the preload port.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants: OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_BNE=5, OP_ADDIU=9, OP_LW=35, OP_SW=43;
  - funct constants: F_JR=8, F_ADDU=33, F_SLT=42;
  - the state enum `cpu_state_t`.
- One sub-module, `mips_regfile`: 32 × DATA_W, two read ports, one write port, register 0 hardwired to 0, synchronous reset clear.

## Test plan
- Preload dmem {-20, 10, 2}, then run `lw $1,0($0)`; `lw $2,1($0)`; `addu $4,$1,$2`; `jr` → `final_result` = -10, `done` at cycle N+25, `invalid_seen` 0.
- `addiu $4,$0,-3` then `slt $4,$4,$0`, then `jr` → `final_result` = 1. Checks sign extension and signed compare.
- `beq $0,$0,+2` skipping `addiu $4,$0,7`, landing on `addiu $4,$0,9`, then `jr` → 9. Same program with `bne` instead of `beq` → 7.
- `sw` of 0x55 to address 3, then `lw $4,3($0)` → 0x55. With the macro undefined → `invalid_seen` 1 and `final_result` 0.
- Opcode 63 followed by `addiu $4,$0,1`; separately `lw` with address 200 → `invalid_seen` 1, execution continues, `final_result` 1.
- Assert `rst` during the EXEC state of an `addiu $4` → all outputs at reset values, R4 = 0. A fresh `start` re-runs the program cleanly.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct encodings, FSM state type and instruction field decode for the multi-cycle core.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] F_JR     = 6'd8;
    localparam logic [5:0] F_ADDU   = 6'd33;
    localparam logic [5:0] F_SLT    = 6'd42;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_MEM,
        S_WB,
        S_DONE
    } cpu_state_t;

    // Decoded instruction fields; rd/funct overlap imm16 by design of the ISA.
    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [15:0] imm16;
    } instr_fields_t;

    function automatic instr_fields_t decode_instr(input logic [31:0] ir);
        instr_fields_t f;
        f.op    = ir[31:26];
        f.rs    = ir[25:21];
        f.rt    = ir[20:16];
        f.rd    = ir[15:11];
        f.funct = ir[5:0];
        f.imm16 = ir[15:0];
        return f;
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 32 x DATA_W register file, two async read ports, one sync write port, r0 hardwired to 0.
// Latency: reads combinational, writes visible the cycle after the write edge.
// Backpressure: none; a write is always accepted.
// Ports: clk/rst (sync, active-high clear), raddr_a/rdata_a, raddr_b/rdata_b, we/waddr/wdata.
module mips_regfile #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [4:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [4:0]        waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: MIPS-subset core, FETCH/DECODE/READ/EXEC/MEM/WB per instruction, internal regfile and dmem.
// Latency: 6 cycles per instruction; done/final_result registered on the edge that leaves the halting WB.
// Backpressure: none; start honoured only in IDLE/DONE, dm_we preload only in IDLE, others ignored.
// Ports: clk, rst (sync active-high), start, dm_we/dm_waddr/dm_wdata (preload), imem_addr/imem_rdata (ROM),
//        done, final_result (Registerfile[OUTPUT_REG] at halt), invalid_seen (sticky).
// Build option: define MIPS_SW_STORE_EN to execute op 43 as sw; otherwise op 43 is an invalid opcode.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int IMEM_AW    = 4,
    parameter int DMEM_DEPTH = 8,
    parameter int PROG_LEN   = 11,
    parameter int OUTPUT_REG = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          dm_we,
    input  logic [$clog2(DMEM_DEPTH)-1:0] dm_waddr,
    input  logic [DATA_W-1:0]             dm_wdata,
    output logic [IMEM_AW-1:0]            imem_addr,
    input  logic [31:0]                   imem_rdata,
    output logic                          done,
    output logic signed [DATA_W-1:0]      final_result,
    output logic                          invalid_seen
);

    localparam int DM_AW = $clog2(DMEM_DEPTH);

    cpu_state_t        state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_next_q, tgt_q;
    logic [31:0]       ir_q;
    instr_fields_t     dec_q;
    logic [DATA_W-1:0] a_q, b_q, alu_q, mdr_q;
    logic              wr_q, load_q, store_q, halt_q, bad_q;
    logic [4:0]        waddr_q;
    logic              done_q, invalid_q;
    logic [DATA_W-1:0] final_q;

    logic [DATA_W-1:0] dmem [DMEM_DEPTH];

    // Execute-stage combinational results
    logic [DATA_W-1:0]  imm_ext, ea, ex_alu;
    logic [IMEM_AW-1:0] imm_pc, ex_pc;
    logic               ea_bad, ex_wr, ex_load, ex_store, ex_halt, ex_bad;
    logic [4:0]         ex_waddr;

    logic [4:0]        rf_raddr_a;
    logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b, wb_data, final_val;
    logic              rf_we;
    logic [DM_AW-1:0]  dm_idx;

    mips_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (rf_raddr_a),
        .rdata_a (rf_rdata_a),
        .raddr_b (dec_q.rt),
        .rdata_b (rf_rdata_b),
        .we      (rf_we),
        .waddr   (waddr_q),
        .wdata   (wb_data)
    );

    // Port A is idle during WB (operands already latched), so it doubles as the halt-time result read.
    assign rf_raddr_a = (state_q == S_WB) ? 5'(OUTPUT_REG) : dec_q.rs;
    assign rf_we      = (state_q == S_WB) && wr_q;
    assign wb_data    = load_q ? mdr_q : alu_q;
    // Forward the same-edge write so a final instruction targeting OUTPUT_REG is captured.
    assign final_val  = (rf_we && (waddr_q == 5'(OUTPUT_REG)) && (waddr_q != 5'd0)) ? wb_data : rf_rdata_a;

    assign imm_ext = DATA_W'($signed(dec_q.imm16));
    assign imm_pc  = IMEM_AW'($signed(dec_q.imm16));
    assign ea      = a_q + imm_ext;
    assign ea_bad  = 64'(ea) >= 64'(DMEM_DEPTH);
    assign dm_idx  = DM_AW'(alu_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_READ;
            S_READ:   state_d = S_EXEC;
            S_EXEC:   state_d = S_MEM;
            S_MEM:    state_d = S_WB;
            S_WB:     state_d = (halt_q || (int'(pc_next_q) >= PROG_LEN)) ? S_DONE : S_FETCH;
            S_DONE:   if (start) state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ex_alu   = '0;
        ex_pc    = pc_q + IMEM_AW'(1);
        ex_wr    = 1'b0;
        ex_waddr = dec_q.rd;
        ex_load  = 1'b0;
        ex_store = 1'b0;
        ex_halt  = 1'b0;
        ex_bad   = 1'b0;
        case (dec_q.op)
            OP_RTYPE: begin
                case (dec_q.funct)
                    F_ADDU: begin
                        ex_alu = a_q + b_q;
                        ex_wr  = 1'b1;
                    end
                    F_SLT: begin
                        ex_alu = ($signed(a_q) < $signed(b_q)) ? DATA_W'(1) : '0;
                        ex_wr  = 1'b1;
                    end
                    F_JR:    ex_halt = 1'b1;
                    default: ex_bad  = 1'b1;
                endcase
            end
            OP_ADDIU: begin
                ex_alu   = a_q + imm_ext;
                ex_wr    = 1'b1;
                ex_waddr = dec_q.rt;
            end
            OP_BEQ: if (a_q == b_q) ex_pc = pc_q + imm_pc;
            OP_BNE: if (a_q != b_q) ex_pc = pc_q + imm_pc;
            OP_J:   ex_pc = tgt_q;
            OP_LW: begin
                ex_alu   = ea;
                ex_waddr = dec_q.rt;
                if (ea_bad) begin
                    ex_bad = 1'b1;
                end else begin
                    ex_wr   = 1'b1;
                    ex_load = 1'b1;
                end
            end
            OP_SW: begin
`ifdef MIPS_SW_STORE_EN
                ex_alu = ea;
                if (ea_bad) ex_bad = 1'b1;
                else        ex_store = 1'b1;
`else
                ex_bad = 1'b1;
`endif
            end
            default: ex_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            pc_next_q <= '0;
            tgt_q     <= '0;
            ir_q      <= '0;
            dec_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            wr_q      <= 1'b0;
            waddr_q   <= '0;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            halt_q    <= 1'b0;
            bad_q     <= 1'b0;
            done_q    <= 1'b0;
            final_q   <= '0;
            invalid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pc_q   <= '0;
                        done_q <= 1'b0;
                    end
                end
                S_FETCH: ir_q <= imem_rdata;
                S_DECODE: begin
                    dec_q <= decode_instr(ir_q);
                    tgt_q <= ir_q[IMEM_AW-1:0];
                end
                S_READ: begin
                    a_q <= rf_rdata_a;
                    b_q <= rf_rdata_b;
                end
                S_EXEC: begin
                    alu_q     <= ex_alu;
                    pc_next_q <= ex_pc;
                    wr_q      <= ex_wr;
                    waddr_q   <= ex_waddr;
                    load_q    <= ex_load;
                    store_q   <= ex_store;
                    halt_q    <= ex_halt;
                    bad_q     <= ex_bad;
                end
                S_MEM: if (load_q) mdr_q <= dmem[dm_idx];
                S_WB: begin
                    pc_q <= pc_next_q;
                    if (bad_q) invalid_q <= 1'b1;
                    if (state_d == S_DONE) begin
                        done_q  <= 1'b1;
                        final_q <= final_val;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                dmem[i] <= '0;
            end
        end else if ((state_q == S_IDLE) && dm_we) begin
            dmem[dm_waddr] <= dm_wdata;
        end else if ((state_q == S_MEM) && store_q) begin
            dmem[dm_idx] <= b_q;
        end
    end

    assign imem_addr    = pc_q;
    assign done         = done_q;
    assign final_result = final_q;
    assign invalid_seen = invalid_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: directed program tests of the multi-cycle core against hand-computed results.
// Latency: checks done timing as 6 cycles per instruction after the start edge.
// Backpressure: n/a.
module tb_mips_multicycle_core;
    import mips_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              dm_we;
    logic [2:0]        dm_waddr;
    logic [7:0]        dm_wdata;
    logic [3:0]        imem_addr;
    logic [31:0]       imem_rdata;
    logic              done;
    logic signed [7:0] final_result;
    logic              invalid_seen;

    logic [31:0] rom [16];
    int passed = 0;
    int total  = 0;

    localparam logic [31:0] JR = {OP_RTYPE, 5'd31, 15'd0, F_JR};

    mips_multicycle_core #(
        .DATA_W(8), .IMEM_AW(4), .DMEM_DEPTH(8), .PROG_LEN(11), .OUTPUT_REG(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .dm_we        (dm_we),
        .dm_waddr     (dm_waddr),
        .dm_wdata     (dm_wdata),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .done         (done),
        .final_result (final_result),
        .invalid_seen (invalid_seen)
    );

    assign imem_rdata = rom[imem_addr];
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] t);
        return {OP_J, t};
    endfunction

    // All tasks start and end on a falling edge.
    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = JR;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; dm_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic preload(input logic [2:0] a, input logic [7:0] d);
        dm_we = 1'b1; dm_waddr = a; dm_wdata = d;
        @(negedge clk);
        dm_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts rising edges after the start edge until done is seen.
    task automatic wait_done(output int edges);
        edges = 0;
        while (done !== 1'b1 && edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (done !== 1'b1) begin
            total++;
            $display("FAIL timeout: done still %b after %0d cycles, want 1", done, edges);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        total++; if (final_result !== 8'h00) $display("FAIL reset_final got %0d want 0", final_result); else passed++;
        total++; if (invalid_seen !== 1'b0) $display("FAIL reset_invalid got %b want 0", invalid_seen); else passed++;
        total++; if (imem_addr !== 4'd0) $display("FAIL reset_pc got %0d want 0", imem_addr); else passed++;
    endtask

    task automatic test_lw_addu();
        int e;
        do_reset();
        clear_rom();
        rom[0] = enc_i(OP_LW, 5'd0, 5'd1, 16'd0);
        rom[1] = enc_i(OP_LW, 5'd0, 5'd2, 16'd1);
        rom[2] = enc_r(5'd1, 5'd2, 5'd4, F_ADDU);
        rom[3] = JR;
        preload(3'd0, 8'hEC);              // -20
        preload(3'd2, 8'd2);
        // Preload on the same edge as start must still land.
        start = 1'b1; dm_we = 1'b1; dm_waddr = 3'd1; dm_wdata = 8'd10;
        @(negedge clk);
        start = 1'b0; dm_we = 1'b0;
        wait_done(e);
        total++; if (e + 1 !== 25) $display("FAIL lw_addu_done_cycle got N+%0d want N+25", e + 1); else passed++;
        total++; if (final_result !== 8'hF6) $display("FAIL lw_addu_final got %0d want -10", final_result); else passed++;
        total++; if (invalid_seen !== 1'b0) $display("FAIL lw_addu_invalid got %b want 0", invalid_seen); else passed++;
    endtask

    task automatic test_signed();
        int e;
        do_reset();
        clear_rom();
        rom[0] = enc_i(OP_ADDIU, 5'd0, 5'd4, 16'hFFFD);
        pulse_start();
        wait_done(e);
        total++; if (e !== 12) $display("FAIL addiu_neg_cycles got %0d want 12", e); else passed++;
        total++; if (final_result !== 8'hFD) $display("FAIL addiu_neg_final got %0d want -3", final_result); else passed++;
        rom[1] = enc_r(5'd4, 5'd0, 5'd4, F_SLT);
        pulse_start();
        wait_done(e);
        total++; if (e !== 18) $display("FAIL slt_cycles got %0d want 18", e); else passed++;
        total++; if (final_result !== 8'd1) $display("FAIL slt_neg_lt_zero got %0d want 1", final_result); else passed++;
        rom[1] = enc_r(5'd0, 5'd4, 5'd4, F_SLT);
        pulse_start();
        wait_done(e);
        total++; if (final_result !== 8'd0) $display("FAIL slt_zero_lt_neg got %0d want 0", final_result); else passed++;
    endtask

    task automatic test_branch();
        int e;
        do_reset();
        clear_rom();
        rom[0] = enc_i(OP_BEQ, 5'd0, 5'd0, 16'd3);
        rom[1] = enc_i(OP_ADDIU, 5'd0, 5'd4, 16'd7);
        rom[2] = JR;
        rom[3] = enc_i(OP_ADDIU, 5'd0, 5'd4, 16'd9);
        rom[4] = JR;
        pulse_start();
        wait_done(e);
        total++; if (final_result !== 8'd9) $display("FAIL beq_taken got %0d want 9", final_result); else passed++;
        total++; if (e !== 18) $display("FAIL beq_cycles got %0d want 18", e); else passed++;
        rom[0] = enc_i(OP_BNE, 5'd0, 5'd0, 16'd3);
        pulse_start();
        wait_done(e);
        total++; if (final_result !== 8'd7) $display("FAIL bne_not_taken got %0d want 7", final_result); else passed++;
        rom[0] = enc_j(26'd3);
        pulse_start();
        wait_done(e);
        total++; if (final_result !== 8'd9) $display("FAIL j_target got %0d want 9", final_result); else passed++;
    endtask

    task automatic test_store();
        int e;
        do_reset();
        clear_rom();
        rom[0] = enc_i(OP_ADDIU, 5'd0, 5'd3, 16'h0055);
        rom[1] = enc_i(OP_SW, 5'd0, 5'd3, 16'd3);
        rom[2] = enc_i(OP_LW, 5'd0, 5'd4, 16'd3);
        pulse_start();
        wait_done(e);
        total++; if (e !== 24) $display("FAIL sw_cycles got %0d want 24", e); else passed++;
`ifdef MIPS_SW_STORE_EN
        total++; if (final_result !== 8'h55) $display("FAIL sw_lw_final got %0d want 85", final_result); else passed++;
        total++; if (invalid_seen !== 1'b0) $display("FAIL sw_invalid got %b want 0", invalid_seen); else passed++;
`else
        total++; if (final_result !== 8'h00) $display("FAIL sw_disabled_final got %0d want 0", final_result); else passed++;
        total++; if (invalid_seen !== 1'b1) $display("FAIL sw_disabled_invalid got %b want 1", invalid_seen); else passed++;
`endif
    endtask

    task automatic test_prog_len();
        int e;
        do_reset();
        clear_rom();
        for (int i = 0; i < 11; i++) rom[i] = enc_i(OP_ADDIU, 5'd4, 5'd4, 16'd1);
        pulse_start();
        wait_done(e);
        total++; if (e !== 66) $display("FAIL prog_len_cycles got %0d want 66", e); else passed++;
        total++; if (final_result !== 8'd11) $display("FAIL prog_len_final got %0d want 11", final_result); else passed++;
    endtask

    task automatic test_restart();
        int e;
        do_reset();
        preload(3'd0, 8'h11);
        clear_rom();
        rom[0] = enc_i(OP_ADDIU, 5'd4, 5'd4, 16'd1);
        pulse_start();
        wait_done(e);
        total++; if (final_result !== 8'd1) $display("FAIL restart_first got %0d want 1", final_result); else passed++;
        pulse_start();
        total++; if (done !== 1'b0) $display("FAIL restart_done_clear got %b want 0", done); else passed++;
        total++; if (imem_addr !== 4'd0) $display("FAIL restart_pc got %0d want 0", imem_addr); else passed++;
        wait_done(e);
        total++; if (final_result !== 8'd2) $display("FAIL restart_regs_kept got %0d want 2", final_result); else passed++;
        preload(3'd0, 8'h66);              // in DONE: must be ignored
        rom[0] = enc_i(OP_LW, 5'd0, 5'd4, 16'd0);
        pulse_start();
        pulse_start();                     // sampled in FETCH: must be ignored
        wait_done(e);
        total++; if (e + 1 !== 12) $display("FAIL start_midrun_cycles got %0d want 12", e + 1); else passed++;
        total++; if (final_result !== 8'h11) $display("FAIL dm_we_in_done got %0d want 17", final_result); else passed++;
    endtask

    task automatic test_invalid();
        int e;
        do_reset();
        clear_rom();
        rom[0] = {6'd63, 26'd0};
        rom[1] = enc_i(OP_ADDIU, 5'd0, 5'd4, 16'd1);
        pulse_start();
        wait_done(e);
        total++; if (invalid_seen !== 1'b1) $display("FAIL bad_opcode_invalid got %b want 1", invalid_seen); else passed++;
        total++; if (final_result !== 8'd1) $display("FAIL bad_opcode_continue got %0d want 1", final_result); else passed++;
        total++; if (e !== 18) $display("FAIL bad_opcode_cycles got %0d want 18", e); else passed++;
        do_reset();
        clear_rom();
        rom[0] = enc_i(OP_ADDIU, 5'd0, 5'd4, 16'd1);
        rom[1] = enc_i(OP_LW, 5'd0, 5'd4, 16'd200);
        pulse_start();
        wait_done(e);
        total++; if (invalid_seen !== 1'b1) $display("FAIL lw_oob_invalid got %b want 1", invalid_seen); else passed++;
        total++; if (final_result !== 8'd1) $display("FAIL lw_oob_no_write got %0d want 1", final_result); else passed++;
        do_reset();
        clear_rom();
        rom[0] = enc_i(OP_ADDIU, 5'd0, 5'd4, 16'd2);
        rom[1] = enc_r(5'd4, 5'd4, 5'd4, 6'd34);
        pulse_start();
        wait_done(e);
        total++; if (invalid_seen !== 1'b1) $display("FAIL bad_funct_invalid got %b want 1", invalid_seen); else passed++;
        total++; if (final_result !== 8'd2) $display("FAIL bad_funct_no_write got %0d want 2", final_result); else passed++;
        clear_rom();
        pulse_start();
        wait_done(e);
        total++; if (invalid_seen !== 1'b1) $display("FAIL invalid_sticky got %b want 1", invalid_seen); else passed++;
    endtask

    task automatic test_reset_mid();
        int e;
        clear_rom();
        rom[0] = enc_i(OP_ADDIU, 5'd0, 5'd4, 16'd5);
        pulse_start();                     // now in FETCH
        repeat (3) @(negedge clk);         // DECODE, READ, EXEC
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (done !== 1'b0) $display("FAIL midrst_done got %b want 0", done); else passed++;
        total++; if (final_result !== 8'h00) $display("FAIL midrst_final got %0d want 0", final_result); else passed++;
        total++; if (invalid_seen !== 1'b0) $display("FAIL midrst_invalid got %b want 0", invalid_seen); else passed++;
        total++; if (imem_addr !== 4'd0) $display("FAIL midrst_pc got %0d want 0", imem_addr); else passed++;
        rom[0] = JR;
        pulse_start();
        wait_done(e);
        total++; if (final_result !== 8'h00) $display("FAIL midrst_r4_cleared got %0d want 0", final_result); else passed++;
        total++; if (e !== 6) $display("FAIL jr_only_cycles got %0d want 6", e); else passed++;
        rom[0] = enc_i(OP_ADDIU, 5'd0, 5'd4, 16'd5);
        pulse_start();
        wait_done(e);
        total++; if (final_result !== 8'd5) $display("FAIL midrst_rerun got %0d want 5", final_result); else passed++;
        total++; if (e !== 12) $display("FAIL midrst_rerun_cycles got %0d want 12", e); else passed++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dm_we = 1'b0; dm_waddr = '0; dm_wdata = '0;
        clear_rom();
        @(negedge clk);
        test_reset();
        test_lw_addu();
        test_signed();
        test_branch();
        test_store();
        test_prog_len();
        test_restart();
        test_invalid();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
